// File: rtl/count_binary_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : count_binary_pkg
//  Purpose  : Register map, CTRL field positions and tick-source encoding
//             shared by the count_binary_ctrl peripheral.
//  Revision : 1.0  initial release
// ============================================================================
package count_binary_pkg;

    localparam logic [2:0] c_addr_ctrl     = 3'd0;
    localparam logic [2:0] c_addr_prescale = 3'd1;
    localparam logic [2:0] c_addr_count    = 3'd2;
    localparam logic [2:0] c_addr_limit    = 3'd3;
    localparam logic [2:0] c_addr_status   = 3'd4;
    localparam logic [2:0] c_addr_switch   = 3'd5;

    localparam int c_ctrl_en      = 0;
    localparam int c_ctrl_dir     = 1;
    localparam int c_ctrl_src_lo  = 2;
    localparam int c_ctrl_src_hi  = 3;
    localparam int c_ctrl_led_sel = 4;
    localparam int c_ctrl_irq_en  = 5;
    localparam int c_ctrl_w       = 6;

    typedef enum logic [1:0] {
        SRC_PRESCALE = 2'b00,
        SRC_STEP     = 2'b01,
        SRC_HOLD     = 2'b10,
        SRC_HOLD_ALT = 2'b11
    } src_e;

endpackage
`default_nettype wire

// File: rtl/count_binary_ctrl_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : sw_debounce
//  Purpose  : Two-flop synchroniser followed by a stable-count debouncer;
//             the output follows the input only after DB_CYC steady cycles.
//  Revision : 1.0  initial release
// ============================================================================
module sw_debounce #(
    parameter int DB_CYC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    output logic o_sw_db
);

    localparam int            c_cnt_w   = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYC - 1);

    logic               r_meta;
    logic               r_sync;
    logic               r_db;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_db   <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_meta <= i_sw;
            r_sync <= r_meta;
            // Any return to the current debounced level restarts the count.
            if (r_sync == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_db  <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

    assign o_sw_db = r_db;

endmodule
`default_nettype wire

// File: rtl/count_binary_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : count_binary_ctrl
//  Purpose  : Avalon-MM binary counter peripheral with limit, prescaler,
//             debounced switch stepping, display/LED conduits and wrap IRQ.
//  Revision : 1.0  initial release
// ============================================================================
module count_binary_ctrl
    import count_binary_pkg::*;
#(
    parameter int               CNT_W   = 16,
    parameter int               SW_W    = 8,
    parameter int               LED_W   = 8,
    parameter int               PRE_W   = 24,
    parameter logic [PRE_W-1:0] PRE_DEF = 24'd49999,
    parameter int               DB_CYC  = 1000
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [2:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic [CNT_W-1:0]  display_external_connection_export,
    input  logic [SW_W-1:0]   switch_external_connection_export,
    output logic [LED_W-1:0]  led_external_connection_export,
    output logic              irq
);

    logic [c_ctrl_w-1:0] r_ctrl;
    logic [PRE_W-1:0]    r_prescale;
    logic [PRE_W-1:0]    r_pre_cnt;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_limit;
    logic                r_wrap;
    logic [31:0]         r_readdata;
    logic [LED_W-1:0]    r_led;
    logic [SW_W-1:0]     r_sw_meta;
    logic [SW_W-1:0]     r_sw_sync;
    logic                r_db_prev;

    logic                w_sw_db;
    logic [LED_W-1:0]    w_sw_led;
    logic [31:0]         w_rd_data;
    logic                w_wr_ctrl, w_wr_prescale, w_wr_count, w_wr_limit, w_wr_status;
    logic                w_en, w_dir, w_pre_run, w_pre_tick, w_step, w_tick;
    logic                w_at_end, w_wrap_evt;
    logic                w_unused_wdata;
    src_e                w_src;

    assign w_wr_ctrl     = avs_write && (avs_address == c_addr_ctrl);
    assign w_wr_prescale = avs_write && (avs_address == c_addr_prescale);
    assign w_wr_count    = avs_write && (avs_address == c_addr_count);
    assign w_wr_limit    = avs_write && (avs_address == c_addr_limit);
    assign w_wr_status   = avs_write && (avs_address == c_addr_status);

    assign w_en       = r_ctrl[c_ctrl_en];
    assign w_dir      = r_ctrl[c_ctrl_dir];
    assign w_src      = src_e'(r_ctrl[c_ctrl_src_hi:c_ctrl_src_lo]);
    assign w_pre_run  = w_en && (w_src == SRC_PRESCALE);
    assign w_pre_tick = w_pre_run && (r_pre_cnt == r_prescale);
    assign w_step     = w_sw_db && !r_db_prev;
    assign w_tick     = w_pre_tick || (w_en && (w_src == SRC_STEP) && w_step);

    // A CPU write to COUNT suppresses the tick, including its wrap event.
    assign w_at_end   = w_dir ? (r_count == '0) : (r_count >= r_limit);
    assign w_wrap_evt = w_tick && !w_wr_count && w_at_end;

    assign w_unused_wdata = ^avs_writedata;

    sw_debounce #(
        .DB_CYC (DB_CYC)
    ) u_sw0_debounce (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .i_sw    (switch_external_connection_export[0]),
        .o_sw_db (w_sw_db)
    );

    if (SW_W >= LED_W) begin : g_sw_led_trunc
        assign w_sw_led = r_sw_sync[LED_W-1:0];
    end else begin : g_sw_led_pad
        assign w_sw_led = {{(LED_W-SW_W){1'b0}}, r_sw_sync};
    end

    always_comb begin
        w_rd_data = '0;
        case (avs_address)
            c_addr_ctrl:     w_rd_data[c_ctrl_w-1:0] = r_ctrl;
            c_addr_prescale: w_rd_data = 32'(r_prescale);
            c_addr_count:    w_rd_data = 32'(r_count);
            c_addr_limit:    w_rd_data = 32'(r_limit);
            c_addr_status:   w_rd_data[0] = r_wrap;
            c_addr_switch:   w_rd_data = 32'(r_sw_sync);
            default:         w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_ctrl     <= '0;
            r_prescale <= PRE_DEF;
            r_pre_cnt  <= '0;
            r_count    <= '0;
            r_limit    <= '1;
            r_wrap     <= 1'b0;
            r_readdata <= '0;
            r_led      <= '0;
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_db_prev  <= 1'b0;
        end else begin
            r_sw_meta <= switch_external_connection_export;
            r_sw_sync <= r_sw_meta;
            r_db_prev <= w_sw_db;

            if (w_wr_ctrl)     r_ctrl     <= avs_writedata[c_ctrl_w-1:0];
            if (w_wr_prescale) r_prescale <= avs_writedata[PRE_W-1:0];
            if (w_wr_limit)    r_limit    <= avs_writedata[CNT_W-1:0];

            if (w_wr_prescale || w_pre_tick) begin
                r_pre_cnt <= '0;
            end else if (w_pre_run) begin
                r_pre_cnt <= r_pre_cnt + PRE_W'(1);
            end

            if (w_wr_count) begin
                r_count <= avs_writedata[CNT_W-1:0];
            end else if (w_tick) begin
                if (w_dir) begin
                    r_count <= w_at_end ? r_limit : (r_count - CNT_W'(1));
                end else begin
                    r_count <= w_at_end ? '0 : (r_count + CNT_W'(1));
                end
            end

            // A wrap in the same cycle as the W1C keeps the flag set.
            if (w_wrap_evt) begin
                r_wrap <= 1'b1;
            end else if (w_wr_status && avs_writedata[0]) begin
                r_wrap <= 1'b0;
            end

            if (avs_read) r_readdata <= w_rd_data;

            r_led <= r_ctrl[c_ctrl_led_sel] ? w_sw_led : r_count[LED_W-1:0];
        end
    end

    assign avs_readdata                       = r_readdata;
    assign display_external_connection_export = r_count;
    assign led_external_connection_export     = r_led;
    assign irq                                = r_wrap && r_ctrl[c_ctrl_irq_en];

endmodule
`default_nettype wire

// File: tb/tb_count_binary_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_count_binary_ctrl
//  Purpose  : Directed scoreboard bench for count_binary_ctrl; bus reads push
//             expected values, a monitor pops them when read data is valid.
//  Revision : 1.0  initial release
// ============================================================================
module tb_count_binary_ctrl;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic [15:0] display;
    logic [7:0]  switches;
    logic [7:0]  led;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_v = 1'b0;

    always #5 clk_clk = ~clk_clk;

    count_binary_ctrl #(
        .CNT_W   (16),
        .SW_W    (8),
        .LED_W   (8),
        .PRE_W   (24),
        .PRE_DEF (24'd49999),
        .DB_CYC  (4)
    ) dut (
        .clk_clk                            (clk_clk),
        .reset_reset_n                      (reset_reset_n),
        .avs_address                        (avs_address),
        .avs_read                           (avs_read),
        .avs_write                          (avs_write),
        .avs_writedata                      (avs_writedata),
        .avs_readdata                       (avs_readdata),
        .display_external_connection_export (display),
        .switch_external_connection_export  (switches),
        .led_external_connection_export     (led),
        .irq                                (irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Read data is valid on the edge that samples avs_read; compare half a cycle later.
    always @(posedge clk_clk) rd_v <= avs_read;

    always @(negedge clk_clk) begin
        if (rd_v) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow: got 0x%08h expected no read", avs_readdata);
            end else begin
                chk(name_q.pop_front(), avs_readdata, exp_q.pop_front());
            end
        end
    end

    // All bus tasks start and end at a falling edge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk_clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(negedge clk_clk);
        avs_read    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_reset_n = 1'b0;
        avs_address   = '0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        switches      = '0;
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);

        // Reset state
        chk("rst_display", 32'(display), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_readdata", avs_readdata, 32'h0);
        rd(3'd0, 32'h0, "rst_ctrl");
        rd(3'd1, 32'd49999, "rst_prescale");
        rd(3'd2, 32'h0, "rst_count");
        rd(3'd3, 32'h0000_FFFF, "rst_limit");
        rd(3'd4, 32'h0, "rst_status");
        rd(3'd5, 32'h0, "rst_switch");
        rd(3'd6, 32'h0, "rst_addr6");

        // Prescaled up-count: one step every PRESCALE+1 = 4 cycles, wrap after 5
        wr(3'd1, 32'd3);
        wr(3'd3, 32'd5);
        wr(3'd0, 32'h01);
        for (int k = 1; k <= 6; k++) begin
            repeat (4) @(negedge clk_clk);
            chk($sformatf("up_step%0d", k), 32'(display), (k == 6) ? 32'd0 : 32'(k));
        end
        chk("irq_masked", 32'(irq), 32'h0);
        wr(3'd0, 32'h20);
        chk("irq_enabled", 32'(irq), 32'h1);
        rd(3'd4, 32'h1, "wrap_set");
        rd(3'd2, 32'h0, "count_after_wrap");
        wr(3'd4, 32'h1);
        chk("irq_cleared", 32'(irq), 32'h0);
        rd(3'd4, 32'h0, "wrap_w1c");

        // Down-count with per-cycle ticks: 0 wraps to LIMIT
        wr(3'd3, 32'd9);
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd0);
        wr(3'd0, 32'h03);
        for (int k = 9; k >= 5; k--) begin
            @(negedge clk_clk);
            chk($sformatf("down_%0d", k), 32'(display), 32'(k));
        end
        wr(3'd0, 32'h00);
        rd(3'd4, 32'h1, "down_wrap");
        rd(3'd2, 32'd4, "down_stop");
        wr(3'd4, 32'h1);

        // Debounced switch step source
        wr(3'd2, 32'd0);
        wr(3'd0, 32'h05);
        switches = 8'h01;
        repeat (2) @(negedge clk_clk);
        switches = 8'h00;
        repeat (12) @(negedge clk_clk);
        chk("glitch_no_step", 32'(display), 32'd0);
        switches = 8'h01;
        repeat (10) @(negedge clk_clk);
        switches = 8'h00;
        repeat (12) @(negedge clk_clk);
        chk("held_one_step", 32'(display), 32'd1);

        // CPU write beats a simultaneous tick (PRESCALE=0 ticks every cycle)
        wr(3'd0, 32'h00);
        wr(3'd3, 32'h0000_FFFF);
        wr(3'd2, 32'd0);
        wr(3'd0, 32'h01);
        wr(3'd2, 32'h1234);
        chk("write_wins_display", 32'(display), 32'h1234);
        wr(3'd0, 32'h00);
        rd(3'd2, 32'h1235, "write_wins_count");

        // COUNT above LIMIT wraps on the next up tick
        wr(3'd3, 32'd5);
        wr(3'd2, 32'd7);
        wr(3'd0, 32'h01);
        @(negedge clk_clk);
        chk("over_limit_wrap", 32'(display), 32'd0);
        wr(3'd0, 32'h00);
        rd(3'd2, 32'd1, "over_limit_next");
        rd(3'd4, 32'h1, "over_limit_flag");
        wr(3'd4, 32'h1);

        // Write truncation to CNT_W
        wr(3'd2, 32'hABCD_5678);
        rd(3'd2, 32'h5678, "count_trunc");
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, 32'h0, "addr7_ignored");

        // LED source selection and switch readback
        wr(3'd0, 32'h10);
        switches = 8'hA5;
        repeat (3) @(negedge clk_clk);
        chk("led_switch", 32'(led), 32'hA5);
        rd(3'd5, 32'hA5, "switch_read");
        wr(3'd0, 32'h00);
        wr(3'd2, 32'h0142);
        @(negedge clk_clk);
        chk("led_count", 32'(led), 32'h42);
        chk("display_count", 32'(display), 32'h0142);

        // Asynchronous reset in mid-run
        wr(3'd3, 32'd3);
        wr(3'd0, 32'h31);
        repeat (3) @(negedge clk_clk);
        chk("irq_running", 32'(irq), 32'h1);
        #2 reset_reset_n = 1'b0;
        #1;
        chk("async_rst_display", 32'(display), 32'h0);
        chk("async_rst_led", 32'(led), 32'h0);
        chk("async_rst_irq", 32'(irq), 32'h0);
        chk("async_rst_readdata", avs_readdata, 32'h0);
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        rd(3'd0, 32'h0, "post_rst_ctrl");
        rd(3'd3, 32'h0000_FFFF, "post_rst_limit");
        rd(3'd1, 32'd49999, "post_rst_prescale");
        rd(3'd4, 32'h0, "post_rst_status");

        repeat (2) @(negedge clk_clk);
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
